dbus_access_ctrl: RTL and testbench

//  Memory-stage sequencer for the data bus. Accepts one load/store per request from the memory stage,

---
 rtl/dbus_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_dbus_access_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_access_ctrl.sv
// Data-bus access sequencer for the memory stage.
// Takes one load/store at a time from the memory stage, rejects misaligned
// accesses, builds the lane-aligned request (size, strobe, data), runs the
// addr_ok/data_ok handshake and holds the pipeline until the access retires.
// A watchdog abandons a request the bus never answers.

package dbus_access_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_LWL  = 4'd6,
    MEM_LWR  = 4'd7,
    MEM_SW   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SB   = 4'd10,
    MEM_SWL  = 4'd11,
    MEM_SWR  = 4'd12
  } mem_t;

endpackage

module dbus_access_ctrl
  import dbus_access_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  mem_t        m_mem_type,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_flush,
  output logic        m_stall,
  output logic        m_done,
  output logic [31:0] m_rdata,
  output logic        m_adel,
  output logic        m_ades,
  output logic        m_bus_err,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  // Watchdog counter just wide enough to reach BUS_TIMEOUT-1; the request is
  // abandoned at the end of its BUS_TIMEOUT-th cycle in REQ+WAIT.
  localparam int unsigned WD_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Decoded view of the operation currently offered by the memory stage.
  logic [1:0]  byte_off;
  logic        op_load;
  logic        op_store;
  logic        op_mis;
  logic        op_legal;
  logic [31:0] lane_addr;
  logic [2:0]  lane_size;
  logic [3:0]  lane_strobe;
  logic [31:0] lane_data;

  // Registered request, held stable for the whole bus transaction.
  logic [31:0] req_addr_reg;
  logic [2:0]  req_size_reg;
  logic [3:0]  req_strobe_reg;
  logic [31:0] req_data_reg;

  logic [31:0]     rdata_reg;
  logic            drop_reg;
  logic            bus_err_reg;
  logic [WD_W-1:0] wd_cnt_reg;

  logic busy;
  logic wd_hit;
  logic accept;
  logic capture;
  logic wd_expire;

  assign byte_off = m_addr[1:0];
  assign busy     = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  assign wd_hit   = (BUS_TIMEOUT != 0) && (wd_cnt_reg == WD_LIMIT);

  // Decode the op: alignment check, bus size, byte strobes and lane-shifted store data.
  always_comb begin
    op_load     = 1'b0;
    op_store    = 1'b0;
    op_mis      = 1'b0;
    lane_addr   = m_addr;
    lane_size   = 3'd2;
    lane_strobe = 4'b0000;
    lane_data   = 32'h0000_0000;
    case (m_mem_type)
      MEM_LW: begin
        op_load = 1'b1;
        op_mis  = (byte_off != 2'b00);
      end
      MEM_LH, MEM_LHU: begin
        op_load   = 1'b1;
        op_mis    = byte_off[0];
        lane_size = 3'd1;
      end
      MEM_LB, MEM_LBU: begin
        op_load   = 1'b1;
        lane_size = 3'd0;
      end
      MEM_LWL, MEM_LWR: begin
        // Unaligned-word loads fetch the whole containing word.
        op_load   = 1'b1;
        lane_addr = {m_addr[31:2], 2'b00};
      end
      MEM_SW: begin
        op_store    = 1'b1;
        op_mis      = (byte_off != 2'b00);
        lane_strobe = 4'b1111;
        lane_data   = m_wdata;
      end
      MEM_SH: begin
        op_store    = 1'b1;
        op_mis      = byte_off[0];
        lane_size   = 3'd1;
        lane_strobe = byte_off[1] ? 4'b1100 : 4'b0011;
        lane_data   = m_wdata << {byte_off[1], 4'b0000};
      end
      MEM_SB: begin
        op_store    = 1'b1;
        lane_size   = 3'd0;
        lane_strobe = 4'b0001 << byte_off;
        lane_data   = m_wdata << {byte_off, 3'b000};
      end
      MEM_SWL: begin
        // Most significant bytes of rt land in the low lanes up to the offset;
        // ~byte_off is 3-byte_off for a 2-bit offset.
        op_store    = 1'b1;
        lane_addr   = {m_addr[31:2], 2'b00};
        lane_strobe = 4'b1111 >> ~byte_off;
        lane_data   = m_wdata >> {~byte_off, 3'b000};
      end
      MEM_SWR: begin
        // Least significant bytes of rt land in lanes from the offset upward.
        op_store    = 1'b1;
        lane_addr   = {m_addr[31:2], 2'b00};
        lane_strobe = 4'b1111 << byte_off;
        lane_data   = m_wdata << {byte_off, 3'b000};
      end
      default: begin
        op_load  = 1'b0;
        op_store = 1'b0;
      end
    endcase
  end

  assign op_legal = (op_load || op_store) && !op_mis;
  assign m_adel   = m_valid && op_load && op_mis;
  assign m_ades   = m_valid && op_store && op_mis;

  // Next-state logic and handshake outputs; reset forces the handshake outputs low.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    wd_expire  = 1'b0;
    m_stall    = 1'b0;
    m_done     = 1'b0;
    dreq_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A pending bus-error pulse blocks acceptance so the faulting op is not
        // reissued before the pipeline reacts to the error.
        if (m_valid && op_legal && !m_flush && !bus_err_reg) begin
          accept     = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dresp_addr_ok && dresp_data_ok) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else if (wd_hit) begin
          wd_expire  = 1'b1;
          state_next = ST_IDLE;
        end else if (dresp_addr_ok) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dresp_data_ok) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else if (wd_hit) begin
          wd_expire  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (!reset) begin
      m_stall    = accept || (busy && !drop_reg);
      m_done     = (state_reg == ST_DONE) && !drop_reg;
      dreq_valid = (state_reg == ST_REQ);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the decoded request in the accept cycle so the bus sees stable fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_reg   <= 32'h0000_0000;
      req_size_reg   <= 3'd0;
      req_strobe_reg <= 4'b0000;
      req_data_reg   <= 32'h0000_0000;
    end else if (accept) begin
      req_addr_reg   <= lane_addr;
      req_size_reg   <= lane_size;
      req_strobe_reg <= lane_strobe;
      req_data_reg   <= lane_data;
    end
  end

  // Capture the bus word on the data_ok cycle of an active transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= 32'h0000_0000;
    end else if (capture) begin
      rdata_reg <= dresp_data;
    end
  end

  // Sticky drop flag: a flushed access still finishes on the bus but does not retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      drop_reg <= 1'b0;
    end else if (busy && m_flush) begin
      drop_reg <= 1'b1;
    end
  end

  // Watchdog: count cycles spent in REQ/WAIT, clear whenever not waiting on the bus.
  always_ff @(posedge clk) begin
    if (reset || !busy) begin
      wd_cnt_reg <= '0;
    end else if (BUS_TIMEOUT != 0) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  // One-cycle bus-error pulse in the IDLE cycle that follows an expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= wd_expire;
    end
  end

  assign m_rdata     = rdata_reg;
  assign m_bus_err   = bus_err_reg;
  assign dreq_addr   = req_addr_reg;
  assign dreq_size   = req_size_reg;
  assign dreq_strobe = req_strobe_reg;
  assign dreq_data   = req_data_reg;

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Scoreboarded bench for dbus_access_ctrl: expected bus requests and retired
// read data are queued when an op is driven and compared when the DUT emits them.
module tb_dbus_access_ctrl;
  import dbus_access_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic        is_store;
  } req_t;

  logic        clk;
  logic        reset;
  logic        m_valid;
  mem_t        m_mem_type;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_flush;
  logic        m_stall;
  logic        m_done;
  logic [31:0] m_rdata;
  logic        m_adel;
  logic        m_ades;
  logic        m_bus_err;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  // Second instance with a short watchdog, driven by its own valid/reset/handshake.
  logic        wd_reset;
  logic        wd_valid;
  logic        wd_stall;
  logic        wd_done;
  logic [31:0] wd_rdata;
  logic        wd_adel;
  logic        wd_ades;
  logic        wd_bus_err;
  logic        wd_dreq_valid;
  logic [31:0] wd_dreq_addr;
  logic [2:0]  wd_dreq_size;
  logic [3:0]  wd_dreq_strobe;
  logic [31:0] wd_dreq_data;
  logic        wd_addr_ok;
  logic        wd_data_ok;

  int n_checks = 0;
  int n_pass   = 0;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  req_t        mon_req;
  logic [31:0] mon_rd;

  dbus_access_ctrl dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_mem_type(m_mem_type),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_flush(m_flush), .m_stall(m_stall),
    .m_done(m_done), .m_rdata(m_rdata), .m_adel(m_adel), .m_ades(m_ades),
    .m_bus_err(m_bus_err), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  dbus_access_ctrl #(.BUS_TIMEOUT(4)) dut_wd (
    .clk(clk), .reset(wd_reset), .m_valid(wd_valid), .m_mem_type(m_mem_type),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_flush(m_flush), .m_stall(wd_stall),
    .m_done(wd_done), .m_rdata(wd_rdata), .m_adel(wd_adel), .m_ades(wd_ades),
    .m_bus_err(wd_bus_err), .dreq_valid(wd_dreq_valid), .dreq_addr(wd_dreq_addr),
    .dreq_size(wd_dreq_size), .dreq_strobe(wd_dreq_strobe), .dreq_data(wd_dreq_data),
    .dresp_addr_ok(wd_addr_ok), .dresp_data_ok(wd_data_ok), .dresp_data(dresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference request built lane by lane from the byte-placement rules.
  function automatic req_t model_req(input mem_t op, input logic [31:0] addr, input logic [31:0] wd);
    req_t r;
    int a;
    logic [7:0] b [4];
    a = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
    r = '0;
    r.addr = addr;
    r.size = 3'd2;
    case (op)
      MEM_LB, MEM_LBU: r.size = 3'd0;
      MEM_LH, MEM_LHU: r.size = 3'd1;
      MEM_LWL, MEM_LWR: r.addr = addr & ~32'h3;
      MEM_SW: begin
        r.is_store = 1'b1;
        r.strobe = 4'hF;
        r.data = wd;
      end
      MEM_SH: begin
        r.is_store = 1'b1;
        r.size = 3'd1;
        for (int i = 0; i < 2; i++) begin
          r.strobe[a+i] = 1'b1;
          r.data[8*(a+i) +: 8] = b[i];
        end
      end
      MEM_SB: begin
        r.is_store = 1'b1;
        r.size = 3'd0;
        r.strobe[a] = 1'b1;
        r.data[8*a +: 8] = b[0];
      end
      MEM_SWL: begin
        r.is_store = 1'b1;
        r.addr = addr & ~32'h3;
        for (int i = 0; i <= a; i++) begin
          r.strobe[i] = 1'b1;
          r.data[8*i +: 8] = b[3-a+i];
        end
      end
      MEM_SWR: begin
        r.is_store = 1'b1;
        r.addr = addr & ~32'h3;
        for (int i = a; i < 4; i++) begin
          r.strobe[i] = 1'b1;
          r.data[8*i +: 8] = b[i-a];
        end
      end
      default: r.size = 3'd2;
    endcase
    return r;
  endfunction

  // Scoreboard: pop a request when the bus accepts it, pop read data on retirement.
  always @(negedge clk) begin
    if (!reset && dreq_valid && dresp_addr_ok) begin
      if (req_q.size() == 0) begin
        check_eq("req_unexpected", 32'h1, 32'h0);
      end else begin
        mon_req = req_q.pop_front();
        check_eq("req_addr", dreq_addr, mon_req.addr);
        check_eq("req_size", 32'(dreq_size), 32'(mon_req.size));
        check_eq("req_strobe", 32'(dreq_strobe), 32'(mon_req.strobe));
        if (mon_req.is_store) check_eq("req_data", dreq_data, mon_req.data);
      end
    end
    if (!reset && m_done) begin
      if (rd_q.size() == 0) begin
        check_eq("done_unexpected", 32'h1, 32'h0);
      end else begin
        mon_rd = rd_q.pop_front();
        check_eq("rdata", m_rdata, mon_rd);
      end
    end
  end

  // One complete access: accept, addr_ok after aok extra REQ cycles, data_ok dok cycles later.
  task automatic run_txn(input string tag, input mem_t op, input logic [31:0] addr,
                         input logic [31:0] wd, input req_t exp, input int aok,
                         input int dok, input logic [31:0] rdata);
    int done_at;
    done_at = 2 + aok + dok;
    step();
    m_valid = 1'b1;
    m_mem_type = op;
    m_addr = addr;
    m_wdata = wd;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    req_q.push_back(exp);
    rd_q.push_back(rdata);
    $display("txn %s op=%s addr=%h wdata=%h aok=%0d dok=%0d", tag, op.name(), addr, wd, aok, dok);
    @(negedge clk);
    check_eq({tag, "_accept_stall"}, 32'(m_stall), 32'h1);
    check_eq({tag, "_no_exc"}, 32'({m_adel, m_ades}), 32'h0);
    for (int k = 1; k <= done_at; k++) begin
      step();
      dresp_addr_ok = (k == 1 + aok);
      dresp_data_ok = (k == 1 + aok + dok);
      dresp_data = dresp_data_ok ? rdata : $urandom;
      @(negedge clk);
      check_eq({tag, "_dreq_valid"}, 32'(dreq_valid), 32'(k <= 1 + aok));
      if (k < done_at) begin
        check_eq({tag, "_stall"}, 32'(m_stall), 32'h1);
        check_eq({tag, "_early_done"}, 32'(m_done), 32'h0);
      end else begin
        check_eq({tag, "_done"}, 32'(m_done), 32'h1);
        check_eq({tag, "_done_stall"}, 32'(m_stall), 32'h0);
      end
    end
  endtask

  task automatic go_idle();
    step();
    m_valid = 1'b0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
  endtask

  mem_t ops [10] = '{MEM_SW, MEM_SH, MEM_SB, MEM_SWL, MEM_SWR,
                     MEM_LW, MEM_LH, MEM_LBU, MEM_LWL, MEM_LWR};

  initial begin
    mem_t        op;
    logic [31:0] a;
    logic [31:0] wd;
    int unsigned off;

    reset = 1'b1; wd_reset = 1'b1;
    m_valid = 1'b0; wd_valid = 1'b0; m_mem_type = MEM_NONE;
    m_addr = '0; m_wdata = '0; m_flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    wd_addr_ok = 1'b0; wd_data_ok = 1'b0;

    // Reset state.
    step(); step();
    @(negedge clk);
    check_eq("rst_stall", 32'(m_stall), 32'h0);
    check_eq("rst_done", 32'(m_done), 32'h0);
    check_eq("rst_dreq_valid", 32'(dreq_valid), 32'h0);
    check_eq("rst_bus_err", 32'(m_bus_err), 32'h0);
    step();
    reset = 1'b0; wd_reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_dreq_valid", 32'(dreq_valid), 32'h0);
    check_eq("post_rst_rdata", m_rdata, 32'h0);
    check_eq("post_rst_strobe", 32'(dreq_strobe), 32'h0);
    check_eq("post_rst_addr", dreq_addr, 32'h0);

    // Spec vectors.
    run_txn("sb_103", MEM_SB, 32'h103, 32'h0000_00AB,
            req_t'{32'h103, 3'd0, 4'b1000, 32'hAB00_0000, 1'b1}, 0, 0, 32'h1111_0000);
    run_txn("swl_101", MEM_SWL, 32'h101, 32'h1122_3344,
            req_t'{32'h100, 3'd2, 4'b0011, 32'h0000_1122, 1'b1}, 0, 0, 32'h2222_0000);
    run_txn("lw_200", MEM_LW, 32'h200, 32'h0,
            req_t'{32'h200, 3'd2, 4'b0000, 32'h0, 1'b0}, 1, 3, 32'hDEAD_BEEF);
    run_txn("sh_102", MEM_SH, 32'h102, 32'h0000_BEEF,
            req_t'{32'h102, 3'd1, 4'b1100, 32'hBEEF_0000, 1'b1}, 0, 1, 32'h3333_0000);
    go_idle();

    // Misaligned ops raise the exception flags and never reach the bus.
    step();
    m_valid = 1'b1; m_mem_type = MEM_SH; m_addr = 32'h101; m_wdata = 32'h5A5A;
    @(negedge clk);
    check_eq("sh_101_ades", 32'(m_ades), 32'h1);
    check_eq("sh_101_adel", 32'(m_adel), 32'h0);
    check_eq("sh_101_stall", 32'(m_stall), 32'h0);
    step();
    m_mem_type = MEM_LW; m_addr = 32'h202;
    @(negedge clk);
    check_eq("sh_101_no_req", 32'(dreq_valid), 32'h0);
    check_eq("lw_202_adel", 32'(m_adel), 32'h1);
    check_eq("lw_202_ades", 32'(m_ades), 32'h0);
    check_eq("lw_202_stall", 32'(m_stall), 32'h0);
    step();
    m_mem_type = MEM_LHU; m_addr = 32'h203;
    @(negedge clk);
    check_eq("lw_202_no_req", 32'(dreq_valid), 32'h0);
    check_eq("lhu_203_adel", 32'(m_adel), 32'h1);
    step();
    m_mem_type = MEM_SW; m_addr = 32'h206;
    @(negedge clk);
    check_eq("sw_206_ades", 32'(m_ades), 32'h1);
    go_idle();
    @(negedge clk);
    check_eq("mis_no_req", 32'(dreq_valid), 32'h0);

    // Flush in IDLE blocks acceptance.
    step();
    m_valid = 1'b1; m_mem_type = MEM_LW; m_addr = 32'h400; m_flush = 1'b1;
    @(negedge clk);
    check_eq("idle_flush_stall", 32'(m_stall), 32'h0);
    step();
    m_valid = 1'b0; m_flush = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_no_req", 32'(dreq_valid), 32'h0);

    // LB flushed during WAIT: bus finishes, no retirement, stall drops next cycle.
    step();
    m_valid = 1'b1; m_mem_type = MEM_LB; m_addr = 32'h305;
    req_q.push_back(model_req(MEM_LB, 32'h305, 32'h0));
    $display("txn lb_flush op=%s addr=%h", m_mem_type.name(), m_addr);
    @(negedge clk);
    check_eq("fl_accept_stall", 32'(m_stall), 32'h1);
    step();
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("fl_req_valid", 32'(dreq_valid), 32'h1);
    step();
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("fl_wait_stall", 32'(m_stall), 32'h1);
    check_eq("fl_wait_dreq_valid", 32'(dreq_valid), 32'h0);
    step();
    m_flush = 1'b1;
    @(negedge clk);
    check_eq("fl_flush_cycle_stall", 32'(m_stall), 32'h1);
    step();
    m_flush = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check_eq("fl_after_stall", 32'(m_stall), 32'h0);
    step();
    dresp_data_ok = 1'b1; dresp_data = 32'h5555_AAAA;
    @(negedge clk);
    check_eq("fl_dok_done", 32'(m_done), 32'h0);
    step();
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check_eq("fl_suppressed_done", 32'(m_done), 32'h0);
    check_eq("fl_done_stall", 32'(m_stall), 32'h0);
    step();
    @(negedge clk);
    check_eq("fl_idle_dreq_valid", 32'(dreq_valid), 32'h0);
    check_eq("fl_idle_done", 32'(m_done), 32'h0);

    // Back-to-back mixed traffic against the lane model.
    for (int n = 0; n < 24; n++) begin
      op = ops[$urandom_range(0, 9)];
      case (op)
        MEM_SW, MEM_LW: off = 0;
        MEM_SH, MEM_LH: off = 2 * $urandom_range(0, 1);
        default:        off = $urandom_range(0, 3);
      endcase
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 63)) + 32'(off);
      wd = $urandom;
      run_txn($sformatf("rnd%0d", n), op, a, wd, model_req(op, a, wd),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
    end
    go_idle();

    // Watchdog instance: no addr_ok ever arrives.
    step();
    wd_valid = 1'b1; m_mem_type = MEM_LW; m_addr = 32'h300;
    $display("txn wd_timeout op=%s addr=%h", m_mem_type.name(), m_addr);
    @(negedge clk);
    check_eq("wd_accept_stall", 32'(wd_stall), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      @(negedge clk);
      check_eq("wd_req_valid", 32'(wd_dreq_valid), 32'h1);
      check_eq("wd_no_err_yet", 32'(wd_bus_err), 32'h0);
    end
    step();
    wd_valid = 1'b0;
    @(negedge clk);
    check_eq("wd_bus_err", 32'(wd_bus_err), 32'h1);
    check_eq("wd_err_dreq_valid", 32'(wd_dreq_valid), 32'h0);
    check_eq("wd_err_stall", 32'(wd_stall), 32'h0);
    step();
    @(negedge clk);
    check_eq("wd_err_pulse_end", 32'(wd_bus_err), 32'h0);

    // Reset in WAIT returns to IDLE with outputs cleared; a late data_ok is ignored.
    step();
    wd_valid = 1'b1; m_mem_type = MEM_LW; m_addr = 32'h340;
    $display("txn wd_reset op=%s addr=%h", m_mem_type.name(), m_addr);
    @(negedge clk);
    check_eq("wdr_accept_stall", 32'(wd_stall), 32'h1);
    step();
    wd_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("wdr_req_valid", 32'(wd_dreq_valid), 32'h1);
    step();
    wd_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("wdr_wait_stall", 32'(wd_stall), 32'h1);
    step();
    wd_reset = 1'b1; wd_valid = 1'b0;
    step();
    wd_reset = 1'b0;
    @(negedge clk);
    check_eq("wdr_dreq_valid", 32'(wd_dreq_valid), 32'h0);
    check_eq("wdr_stall", 32'(wd_stall), 32'h0);
    check_eq("wdr_done", 32'(wd_done), 32'h0);
    check_eq("wdr_bus_err", 32'(wd_bus_err), 32'h0);
    check_eq("wdr_addr", wd_dreq_addr, 32'h0);
    check_eq("wdr_size", 32'(wd_dreq_size), 32'h0);
    check_eq("wdr_strobe", 32'(wd_dreq_strobe), 32'h0);
    check_eq("wdr_data", wd_dreq_data, 32'h0);
    check_eq("wdr_exc", 32'({wd_adel, wd_ades}), 32'h0);
    step();
    wd_data_ok = 1'b1; dresp_data = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("wdr_late_dok_done", 32'(wd_done), 32'h0);
    step();
    wd_data_ok = 1'b0;
    @(negedge clk);
    check_eq("wdr_late_done", 32'(wd_done), 32'h0);
    check_eq("wdr_late_rdata", wd_rdata, 32'h0);
    check_eq("wdr_late_dreq_valid", 32'(wd_dreq_valid), 32'h0);

    // Every queued expectation must have been consumed.
    check_eq("req_q_drained", 32'(req_q.size()), 32'h0);
    check_eq("rd_q_drained", 32'(rd_q.size()), 32'h0);
    check_eq("main_no_bus_err", 32'(m_bus_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
